// File: rtl/display_arb_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package display_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam int DIG_W = 4;
   localparam int VAL_W = 16;

   // Bits needed to hold a down-counter loaded with cycles-1 (never below 1).
   function automatic int cnt_width(input int cycles);
      int w;
      w = $clog2(cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/display_arbiter_rr_pick.sv
// Combinational round-robin picker: search starts one past the last owner and wraps.
module rr_pick
   import display_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   winner,
   output logic               valid
);

   always_comb begin
      int idx;
      idx    = 0;
      grant  = '0;
      winner = '0;
      valid  = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last) + k) % NUM_REQ;
         if (!valid && req[idx]) begin
            valid      = 1'b1;
            grant[idx] = 1'b1;
            winner     = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of the 4-digit display; latches the winner's value for HOLD_CYCLES.
// Build option DISPLAY_ARB_GAP_EN inserts GAP_CYCLES of blanking between owners.
module display_arbiter
   import display_arb_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int HOLD_CYCLES = 100000000,
   parameter int GAP_CYCLES  = 1000000
) (
   input  logic                       clk,
   input  logic                       clr,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [VAL_W*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]         ack,
   output logic [DIG_W-1:0]           dig1,
   output logic [DIG_W-1:0]           dig2,
   output logic [DIG_W-1:0]           dig3,
   output logic [DIG_W-1:0]           dig4,
   output logic                       blank,
   output logic [$clog2(NUM_REQ)-1:0] owner,
   output logic                       busy
);

   localparam int IDX_W  = $clog2(NUM_REQ);
   localparam int HOLD_W = cnt_width(HOLD_CYCLES);
`ifdef DISPLAY_ARB_GAP_EN
   localparam int GAP_W  = cnt_width(GAP_CYCLES);
   localparam int CNT_W  = (HOLD_W > GAP_W) ? HOLD_W : GAP_W;
`else
   localparam int CNT_W  = HOLD_W;
`endif

   if (NUM_REQ < 2 || NUM_REQ > 8 || HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_param
      $error("display_arbiter: illegal parameter value");
   end

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [VAL_W-1:0]   val, val_n;
   logic [NUM_REQ-1:0] ack_n;
   logic               blank_n, busy_n;
   logic [IDX_W-1:0]   owner_n;
   // Priority pointer is separate from owner so that reset gives requester 0 first pick.
   logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;

   logic [NUM_REQ-1:0] pick_grant;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_valid;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req    (req),
      .last   (rr_ptr),
      .grant  (pick_grant),
      .winner (pick_idx),
      .valid  (pick_valid)
   );

   always_ff @(posedge clk) begin
      if (!clr) begin
         state  <= IDLE;
         cnt    <= '0;
         val    <= '0;
         ack    <= '0;
         blank  <= 1'b1;
         owner  <= '0;
         busy   <= 1'b0;
         rr_ptr <= IDX_W'(NUM_REQ - 1);
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         val    <= val_n;
         ack    <= ack_n;
         blank  <= blank_n;
         owner  <= owner_n;
         busy   <= busy_n;
         rr_ptr <= rr_ptr_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      val_n    = val;
      ack_n    = '0;
      blank_n  = blank;
      owner_n  = owner;
      busy_n   = busy;
      rr_ptr_n = rr_ptr;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               ack_n    = pick_grant;
               val_n    = req_data[int'(pick_idx)*VAL_W +: VAL_W];
               owner_n  = pick_idx;
               rr_ptr_n = pick_idx;
               blank_n  = 1'b0;
               busy_n   = 1'b1;
               cnt_n    = CNT_W'(HOLD_CYCLES - 1);
               state_n  = SHOW;
            end
         end
         SHOW: begin
            if (cnt == '0) begin
`ifdef DISPLAY_ARB_GAP_EN
               cnt_n   = CNT_W'(GAP_CYCLES - 1);
               blank_n = 1'b1;
               state_n = GAP;
`else
               busy_n  = 1'b0;
               state_n = IDLE;
`endif
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
`ifdef DISPLAY_ARB_GAP_EN
         GAP: begin
            if (cnt == '0) begin
               busy_n  = 1'b0;
               state_n = IDLE;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   assign dig1 = val[15:12];
   assign dig2 = val[11:8];
   assign dig3 = val[7:4];
   assign dig4 = val[3:0];

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with NUM_REQ=2, HOLD_CYCLES=4, GAP_CYCLES=2.
module tb_display_arbiter;

   localparam int H = 4;
`ifdef DISPLAY_ARB_GAP_EN
   localparam int G = 2;
`else
   localparam int G = 0;
`endif

   logic        clk = 1'b0;
   logic        clr;
   logic [1:0]  req;
   logic [31:0] req_data;
   logic [1:0]  ack;
   logic [3:0]  dig1, dig2, dig3, dig4;
   logic        blank;
   logic [0:0]  owner;
   logic        busy;

   int n_chk = 0;
   int n_err = 0;

   display_arbiter #(
      .NUM_REQ     (2),
      .HOLD_CYCLES (H),
      .GAP_CYCLES  (2)
   ) dut (
      .clk      (clk),
      .clr      (clr),
      .req      (req),
      .req_data (req_data),
      .ack      (ack),
      .dig1     (dig1),
      .dig2     (dig2),
      .dig3     (dig3),
      .dig4     (dig4),
      .blank    (blank),
      .owner    (owner),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] digs();
      return {dig1, dig2, dig3, dig4};
   endfunction

   initial begin
      int n_ack;
      int cyc;
      int last_cyc;
      int exp_idx [4] = '{0, 1, 0, 1};

      clr = 1'b0; req = 2'b00; req_data = '0;
      tick(); tick();
      chk("rst_dig",   32'(digs()), 32'h0);
      chk("rst_blank", 32'(blank),  32'd1);
      chk("rst_busy",  32'(busy),   32'd0);
      chk("rst_ack",   32'(ack),    32'd0);
      chk("rst_owner", 32'(owner),  32'd0);
      clr = 1'b1;

      // single grant; requester 1 pulses req for one SHOW cycle and withdraws
      tick();
      chk("idle_ack", 32'(ack), 32'd0);
      req_data[15:0] = 16'h1234; req = 2'b01;
      tick();
      chk("g1_ack",   32'(ack),    32'b01);
      chk("g1_dig",   32'(digs()), 32'h1234);
      chk("g1_blank", 32'(blank),  32'd0);
      chk("g1_busy",  32'(busy),   32'd1);
      req = 2'b00;
      for (int i = 1; i <= H + G; i++) begin
         tick();
         chk("g1_busy_run",  32'(busy),  32'(i < H + G));
         chk("g1_blank_run", 32'(blank), 32'(G > 0 && i >= H));
         chk("g1_ack_run",   32'(ack),   32'd0);
         if (i == 1) req = 2'b10;
         if (i == 2) req = 2'b00;
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("wd_ack",   32'(ack),   32'd0);
         chk("wd_busy",  32'(busy),  32'd0);
         chk("wd_owner", 32'(owner), 32'd0);
         chk("wd_dig",   32'(digs()), 32'h1234);
      end

      // reset in the middle of SHOW
      req_data[15:0] = 16'hBEEF; req = 2'b01;
      tick();
      chk("g2_ack", 32'(ack),    32'b01);
      chk("g2_dig", 32'(digs()), 32'hBEEF);
      req = 2'b00;
      tick();
      clr = 1'b0; req = 2'b11; req_data = {16'h5555, 16'hAAAA};
      tick();
      chk("mrst_dig",   32'(digs()), 32'h0);
      chk("mrst_owner", 32'(owner),  32'd0);
      chk("mrst_blank", 32'(blank),  32'd1);
      chk("mrst_busy",  32'(busy),   32'd0);
      chk("mrst_ack",   32'(ack),    32'd0);
      clr = 1'b1;

      // both requesting continuously: alternate starting from requester 0
      n_ack = 0; cyc = 0; last_cyc = 0;
      while (n_ack < 4 && cyc < 80) begin
         tick();
         cyc++;
         if (ack != 2'b00) begin
            chk("sim_ack",   32'(ack),   32'(1 << exp_idx[n_ack]));
            chk("sim_owner", 32'(owner), 32'(exp_idx[n_ack]));
            chk("sim_dig",   32'(digs()), (exp_idx[n_ack] == 0) ? 32'hAAAA : 32'h5555);
            if (n_ack == 0) chk("sim_first", 32'(cyc), 32'd1);
            else            chk("sim_space", 32'(cyc - last_cyc), 32'(H + 1 + G));
            last_cyc = cyc;
            n_ack++;
         end
      end
      chk("sim_count", 32'(n_ack), 32'd4);
      req = 2'b00;

      cyc = 0;
      while (busy && cyc < 50) begin
         tick();
         cyc++;
      end
      chk("drain_busy", 32'(busy), 32'd0);

      // request raised during owner 0's SHOW is held and served at first IDLE edge
      req = 2'b01;
      tick();
      chk("g3_ack", 32'(ack), 32'b01);
      req = 2'b00;
      tick();
      chk("g3_ack_off", 32'(ack), 32'd0);
      req = 2'b10;
      for (int k = 2; k <= H + 1 + G; k++) begin
         tick();
         chk("pend_ack", 32'(ack), (k == H + 1 + G) ? 32'b10 : 32'b00);
      end
      chk("pend_owner", 32'(owner),  32'd1);
      chk("pend_dig",   32'(digs()), 32'h5555);
      chk("pend_blank", 32'(blank),  32'd0);
      req = 2'b00;

      // end of SHOW: straight to IDLE, or blanked GAP first
      for (int k = 1; k <= H; k++) tick();
      chk("end_busy",  32'(busy),   32'(G > 0));
      chk("end_blank", 32'(blank),  32'(G > 0));
      chk("end_dig",   32'(digs()), 32'h5555);
`ifdef DISPLAY_ARB_GAP_EN
      tick();
      chk("gap_blank", 32'(blank), 32'd1);
      chk("gap_busy",  32'(busy),  32'd1);
      chk("gap_dig",   32'(digs()), 32'h5555);
      tick();
      chk("gapx_busy",  32'(busy),  32'd0);
      chk("gapx_blank", 32'(blank), 32'd1);
      chk("gapx_owner", 32'(owner), 32'd1);
      req = 2'b01;
      tick();
      chk("gnew_ack",   32'(ack),   32'b01);
      chk("gnew_blank", 32'(blank), 32'd0);
      chk("gnew_dig",   32'(digs()), 32'hAAAA);
      req = 2'b00;
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
